// File: rtl/data_ram_ctrl_if.sv
// Request/response bus between the MEM stage and the data RAM block.
// The master issues load/store requests and consumes responses.
// The slave is the RAM controller.
interface data_ram_ctrl_if #(
  parameter int ADDR_WIDTH = 32
);
  logic                  req_valid;
  logic                  req_ready;
  logic                  req_we;
  logic [2:0]            req_funct3;
  logic [ADDR_WIDTH-1:0] req_addr;
  logic [31:0]           req_wdata;
  logic                  rsp_valid;
  logic                  rsp_ready;
  logic [31:0]           rsp_rdata;
  logic                  rsp_err;

  modport master (
    output req_valid, req_we, req_funct3, req_addr, req_wdata, rsp_ready,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err
  );

  modport slave (
    input  req_valid, req_we, req_funct3, req_addr, req_wdata, rsp_ready,
    output req_ready, rsp_valid, rsp_rdata, rsp_err
  );
endinterface

// File: rtl/data_ram_ctrl.sv
// Data memory for the RV32 MEM stage: one outstanding load/store at a time,
// RV32I byte/half/word sizing, sign/zero extension, byte-lane stores and a
// configurable response latency. Bad accesses are flagged, never written.
module data_ram_ctrl #(
  parameter int ADDR_WIDTH  = 32,
  parameter int DEPTH_WORDS = 256,
  parameter int READ_LAT    = 1
) (
  input logic            clk,
  input logic            reset,
  data_ram_ctrl_if.slave bus
);
  localparam int IDX_W = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  state_t           state_reg, state_next;
  logic [2:0]       cnt_reg, cnt_next;
  logic             we_reg;
  logic [2:0]       funct3_reg;
  logic [1:0]       addr_lo_reg;
  logic [IDX_W-1:0] idx_reg;
  logic             err_reg;

  logic                  accept;
  logic [ADDR_WIDTH-3:0] word_addr;
  logic [IDX_W-1:0]      req_idx;
  logic                  f3_ok;
  logic                  misaligned;
  logic                  out_of_range;
  logic                  req_err;

  logic             wr_en;
  logic [3:0]       wr_be;
  logic [31:0]      wr_data;
  logic             rd_en;
  logic [IDX_W-1:0] rd_idx;
  logic [31:0]      rd_word;

  logic        req_ready_c;
  logic [7:0]  sel_byte;
  logic [15:0] sel_half;
  logic [31:0] load_data;

  assign word_addr = bus.req_addr[ADDR_WIDTH-1:2];
  assign req_idx   = bus.req_addr[IDX_W+1:2];
  assign accept    = (state_reg == IDLE) && bus.req_valid && !reset;

  // Classify the incoming request: legal width code, alignment and range.
  always_comb begin
    f3_ok      = 1'b0;
    misaligned = 1'b0;
    if (bus.req_we) begin
      f3_ok = (bus.req_funct3 == 3'b000) || (bus.req_funct3 == 3'b001) ||
              (bus.req_funct3 == 3'b010);
    end else begin
      f3_ok = (bus.req_funct3 == 3'b000) || (bus.req_funct3 == 3'b001) ||
              (bus.req_funct3 == 3'b010) || (bus.req_funct3 == 3'b100) ||
              (bus.req_funct3 == 3'b101);
    end
    case (bus.req_funct3[1:0])
      2'b01:   misaligned = bus.req_addr[0];
      2'b10:   misaligned = (bus.req_addr[1:0] != 2'b00);
      default: misaligned = 1'b0;
    endcase
    out_of_range = (64'(word_addr) >= 64'(DEPTH_WORDS));
    req_err      = !f3_ok || misaligned || out_of_range;
  end

  // Byte enables and lane-replicated store data; unselected lanes are masked.
  always_comb begin
    wr_be   = 4'b0000;
    wr_data = bus.req_wdata;
    case (bus.req_funct3[1:0])
      2'b00: begin
        wr_be   = 4'b0001 << bus.req_addr[1:0];
        wr_data = {4{bus.req_wdata[7:0]}};
      end
      2'b01: begin
        wr_be   = bus.req_addr[1] ? 4'b1100 : 4'b0011;
        wr_data = {2{bus.req_wdata[15:0]}};
      end
      2'b10: begin
        wr_be   = 4'b1111;
        wr_data = bus.req_wdata;
      end
      default: wr_be = 4'b0000;
    endcase
  end

  assign wr_en = accept && bus.req_we && !req_err;

  // One byte-wide RAM per lane so partial stores need no read-modify-write.
  for (genvar gi = 0; gi < 4; gi++) begin : g_lane
    logic [7:0] lane_mem [DEPTH_WORDS];
    logic [7:0] rd_q;

    // Lane write on store accept; registered read on the edge entering RESP.
    always_ff @(posedge clk) begin
      if (wr_en && wr_be[gi]) begin
        lane_mem[req_idx] <= wr_data[8*gi +: 8];
      end
      if (rd_en) begin
        rd_q <= lane_mem[rd_idx];
      end
    end

    assign rd_word[8*gi +: 8] = rd_q;
  end

  // State, latency counter and latched request fields.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg   <= IDLE;
      cnt_reg     <= 3'd0;
      we_reg      <= 1'b0;
      funct3_reg  <= 3'd0;
      addr_lo_reg <= 2'd0;
      idx_reg     <= '0;
      err_reg     <= 1'b0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      if (accept) begin
        we_reg      <= bus.req_we;
        funct3_reg  <= bus.req_funct3;
        addr_lo_reg <= bus.req_addr[1:0];
        idx_reg     <= req_idx;
        err_reg     <= req_err;
      end
    end
  end

  // Next-state logic; also decides when and where the array is read.
  // With a latency of one the read happens on the accept edge itself, so
  // the index comes straight from the request rather than the latch.
  always_comb begin
    state_next  = state_reg;
    cnt_next    = cnt_reg;
    req_ready_c = 1'b0;
    rd_en       = 1'b0;
    rd_idx      = idx_reg;
    case (state_reg)
      IDLE: begin
        req_ready_c = 1'b1;
        rd_idx      = req_idx;
        if (bus.req_valid) begin
          if (READ_LAT <= 1) begin
            state_next = RESP;
            rd_en      = !bus.req_we && !req_err;
          end else begin
            state_next = WAIT;
            cnt_next   = 3'(READ_LAT - 1);
          end
        end
      end
      WAIT: begin
        cnt_next = cnt_reg - 3'd1;
        if (cnt_reg <= 3'd1) begin
          state_next = RESP;
          rd_en      = !we_reg && !err_reg;
        end
      end
      RESP: begin
        if (bus.rsp_ready) begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Pick the addressed byte/half and extend it according to the load type.
  always_comb begin
    sel_byte  = rd_word[7:0];
    sel_half  = addr_lo_reg[1] ? rd_word[31:16] : rd_word[15:0];
    load_data = 32'd0;
    case (addr_lo_reg)
      2'd0: sel_byte = rd_word[7:0];
      2'd1: sel_byte = rd_word[15:8];
      2'd2: sel_byte = rd_word[23:16];
      2'd3: sel_byte = rd_word[31:24];
      default: sel_byte = rd_word[7:0];
    endcase
    case (funct3_reg)
      3'b000:  load_data = {{24{sel_byte[7]}}, sel_byte};
      3'b001:  load_data = {{16{sel_half[15]}}, sel_half};
      3'b010:  load_data = rd_word;
      3'b100:  load_data = {24'd0, sel_byte};
      3'b101:  load_data = {16'd0, sel_half};
      default: load_data = 32'd0;
    endcase
  end

  assign bus.req_ready = req_ready_c;
  assign bus.rsp_valid = (state_reg == RESP);
  assign bus.rsp_err   = (state_reg == RESP) && err_reg;
  assign bus.rsp_rdata = ((state_reg == RESP) && !we_reg && !err_reg) ? load_data : 32'd0;
endmodule

// File: tb/tb_data_ram_ctrl.sv
// Scoreboard bench for data_ram_ctrl: two instances (latency 1 and 3) run
// the same directed vectors; monitors pop expected responses per handshake.
module tb_data_ram_ctrl;
  logic clk = 1'b0;
  logic rst1;
  logic rst3;

  always #5 clk = ~clk;

  data_ram_ctrl_if #(.ADDR_WIDTH(32)) b1 ();
  data_ram_ctrl_if #(.ADDR_WIDTH(32)) b3 ();

  data_ram_ctrl #(.ADDR_WIDTH(32), .DEPTH_WORDS(256), .READ_LAT(1)) dut1 (
    .clk(clk), .reset(rst1), .bus(b1.slave)
  );
  data_ram_ctrl #(.ADDR_WIDTH(32), .DEPTH_WORDS(256), .READ_LAT(3)) dut3 (
    .clk(clk), .reset(rst3), .bus(b3.slave)
  );

  typedef struct packed {
    logic [31:0] rdata;
    logic        err;
  } exp_t;

  exp_t q1[$];
  exp_t q3[$];
  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
    total++;
    if (act !== want) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, want);
    end
  endtask

  // Monitor for the latency-1 instance: a handshake completes on the next posedge.
  always @(negedge clk) begin
    if (b1.rsp_valid && b1.rsp_ready) begin
      if (q1.size() == 0) begin
        total++;
        bad++;
        $display("FAIL rsp1_unexpected: got rdata=%h err=%0d want none", b1.rsp_rdata, b1.rsp_err);
      end else begin
        exp_t e;
        e = q1.pop_front();
        $display("rsp1 rdata=%h err=%0d (want %h/%0d)", b1.rsp_rdata, b1.rsp_err, e.rdata, e.err);
        chk("rsp1_rdata", b1.rsp_rdata, e.rdata);
        chk("rsp1_err", {31'd0, b1.rsp_err}, {31'd0, e.err});
      end
    end
  end

  // Monitor for the latency-3 instance.
  always @(negedge clk) begin
    if (b3.rsp_valid && b3.rsp_ready) begin
      if (q3.size() == 0) begin
        total++;
        bad++;
        $display("FAIL rsp3_unexpected: got rdata=%h err=%0d want none", b3.rsp_rdata, b3.rsp_err);
      end else begin
        exp_t e;
        e = q3.pop_front();
        $display("rsp3 rdata=%h err=%0d (want %h/%0d)", b3.rsp_rdata, b3.rsp_err, e.rdata, e.err);
        chk("rsp3_rdata", b3.rsp_rdata, e.rdata);
        chk("rsp3_err", {31'd0, b3.rsp_err}, {31'd0, e.err});
      end
    end
  end

  task automatic set_req(input int sel, input logic v, input logic we, input logic [2:0] f3,
                         input logic [31:0] a, input logic [31:0] wd);
    if (sel == 1) begin
      b1.req_valid = v; b1.req_we = we; b1.req_funct3 = f3; b1.req_addr = a; b1.req_wdata = wd;
    end else begin
      b3.req_valid = v; b3.req_we = we; b3.req_funct3 = f3; b3.req_addr = a; b3.req_wdata = wd;
    end
  endtask

  function automatic logic rdy(input int sel);
    return (sel == 1) ? b1.req_ready : b3.req_ready;
  endfunction

  // Called just after a posedge; returns just after the accepting posedge.
  task automatic issue(input int sel, input logic we, input logic [2:0] f3, input logic [31:0] a,
                       input logic [31:0] wd, input logic [31:0] exp_d, input logic exp_e);
    exp_t e;
    int n;
    n = 0;
    e.rdata = exp_d;
    e.err   = exp_e;
    if (sel == 1) q1.push_back(e); else q3.push_back(e);
    set_req(sel, 1'b1, we, f3, a, wd);
    @(negedge clk);
    while (!rdy(sel) && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50) begin
      total++;
      bad++;
      $display("FAIL accept_timeout: got req_ready=0 for %0d cycles want 1", n);
    end
    @(posedge clk);
    #1;
    set_req(sel, 1'b0, 1'b0, 3'd0, 32'd0, 32'd0);
    $display("req%0d we=%0d f3=%0d addr=%h wdata=%h", sel, we, f3, a, wd);
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((q1.size() != 0 || q3.size() != 0) && n < 100) begin
      @(posedge clk);
      n++;
    end
    #1;
    chk("drain_pending", 32'(q1.size() + q3.size()), 32'd0);
  endtask

  task automatic run_vec(input int s);
    issue(s, 1, 3'b010, 32'h04, 32'h800000FF, 32'h0, 0);
    issue(s, 0, 3'b000, 32'h04, 32'h0, 32'hFFFFFFFF, 0);
    issue(s, 0, 3'b100, 32'h04, 32'h0, 32'h000000FF, 0);
    issue(s, 0, 3'b000, 32'h07, 32'h0, 32'hFFFFFF80, 0);
    issue(s, 0, 3'b101, 32'h06, 32'h0, 32'h00008000, 0);
    issue(s, 1, 3'b010, 32'h08, 32'hAABBCCDD, 32'h0, 0);
    issue(s, 1, 3'b001, 32'h0A, 32'hFFFF1234, 32'h0, 0);
    issue(s, 0, 3'b010, 32'h08, 32'h0, 32'h1234CCDD, 0);
    issue(s, 0, 3'b101, 32'h0A, 32'h0, 32'h00001234, 0);
    issue(s, 0, 3'b001, 32'h08, 32'h0, 32'hFFFFCCDD, 0);
    issue(s, 1, 3'b000, 32'h09, 32'h0000005A, 32'h0, 0);
    issue(s, 0, 3'b010, 32'h08, 32'h0, 32'h12345ADD, 0);
    issue(s, 1, 3'b010, 32'h00, 32'h01020304, 32'h0, 0);
    issue(s, 0, 3'b010, 32'h02, 32'h0, 32'h0, 1);
    issue(s, 1, 3'b001, 32'h01, 32'h0000BEEF, 32'h0, 1);
    issue(s, 0, 3'b001, 32'h03, 32'h0, 32'h0, 1);
    issue(s, 1, 3'b100, 32'h00, 32'hFFFFFFFF, 32'h0, 1);
    issue(s, 0, 3'b011, 32'h00, 32'h0, 32'h0, 1);
    issue(s, 0, 3'b010, 32'h00, 32'h0, 32'h01020304, 0);
    issue(s, 0, 3'b010, 32'h400, 32'h0, 32'h0, 1);
    issue(s, 1, 3'b010, 32'h400, 32'h55555555, 32'h0, 1);
    issue(s, 0, 3'b010, 32'h00, 32'h0, 32'h01020304, 0);
    issue(s, 1, 3'b010, 32'h3FC, 32'hDEADBEEF, 32'h0, 0);
    issue(s, 0, 3'b000, 32'h3FD, 32'h0, 32'hFFFFFFBE, 0);
    issue(s, 0, 3'b010, 32'h3FC, 32'h0, 32'hDEADBEEF, 0);
    issue(s, 0, 3'b010, 32'hFFFFFFFC, 32'h0, 32'h0, 1);
  endtask

  initial begin
    rst1 = 1'b1;
    rst3 = 1'b1;
    set_req(1, 1'b0, 1'b0, 3'd0, 32'd0, 32'd0);
    set_req(3, 1'b0, 1'b0, 3'd0, 32'd0, 32'd0);
    b1.rsp_ready = 1'b1;
    b3.rsp_ready = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst1_req_ready", {31'd0, b1.req_ready}, 32'd1);
    chk("rst1_rsp_valid", {31'd0, b1.rsp_valid}, 32'd0);
    chk("rst1_rsp_rdata", b1.rsp_rdata, 32'd0);
    chk("rst1_rsp_err", {31'd0, b1.rsp_err}, 32'd0);
    chk("rst3_req_ready", {31'd0, b3.req_ready}, 32'd1);
    chk("rst3_rsp_valid", {31'd0, b3.rsp_valid}, 32'd0);
    @(posedge clk);
    #1;
    rst1 = 1'b0;
    rst3 = 1'b0;

    run_vec(1);
    run_vec(3);
    drain();

    // Latency 3 with a stalled consumer: response appears in cycle 3 and holds.
    b3.rsp_ready = 1'b0;
    issue(3, 0, 3'b010, 32'h04, 32'h0, 32'h800000FF, 0);
    for (int k = 1; k <= 3; k++) begin
      @(negedge clk);
      chk($sformatf("lat_valid_c%0d", k), {31'd0, b3.rsp_valid}, (k == 3) ? 32'd1 : 32'd0);
    end
    for (int i = 0; i < 5; i++) begin
      chk($sformatf("hold_rdata_%0d", i), b3.rsp_rdata, 32'h800000FF);
      chk($sformatf("hold_req_ready_%0d", i), {31'd0, b3.req_ready}, 32'd0);
      chk($sformatf("hold_valid_%0d", i), {31'd0, b3.rsp_valid}, 32'd1);
      @(negedge clk);
    end
    @(posedge clk);
    #1;
    b3.rsp_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk("release_req_ready", {31'd0, b3.req_ready}, 32'd1);
    chk("release_rsp_valid", {31'd0, b3.rsp_valid}, 32'd0);
    @(posedge clk);
    #1;

    // Reset while a store waits for its response: store stays, response dropped.
    issue(3, 1, 3'b010, 32'h10, 32'h11223344, 32'h0, 0);
    drain();
    issue(3, 1, 3'b010, 32'h14, 32'hCAFEF00D, 32'h0, 0);
    rst3 = 1'b1;
    @(posedge clk);
    #1;
    rst3 = 1'b0;
    void'(q3.pop_back());
    @(negedge clk);
    chk("midrst_rsp_valid", {31'd0, b3.rsp_valid}, 32'd0);
    chk("midrst_req_ready", {31'd0, b3.req_ready}, 32'd1);
    @(posedge clk);
    #1;
    issue(3, 0, 3'b010, 32'h14, 32'h0, 32'hCAFEF00D, 0);
    issue(3, 0, 3'b010, 32'h10, 32'h0, 32'h11223344, 0);
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
